jogador_automatico: RTL and testbench
=====================================

Name: jogador_automatico

Overview:
Hardware autoplayer for the memory game circuit: sits on the player side of the game's leds/botoes interface, the counterpart of the game core.
- Observes the LED sequence the game displays each round and records it.
- Replays the recorded sequence on botoes with fixed press/release timing.
- Stops when the game reports ganhou or perdeu.
- Used for on-board self-test and for driving long regression runs in place of manual play.

Parameters:
HOLD, 5, clock cycles each button stays pressed
GAP, 5, clock cycles of botoes=0 between consecutive presses
JOGAR_CICLOS, 5, clock cycles jogar is held high at start
SILENCIO, 20, consecutive cycles of leds=0 that end the display phase
PROFUNDIDADE, 16, capture memory depth (entries)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start request, sampled high in INICIAL or FIM
leds  in  4  game LED outputs being observed
ganhou  in  1  game win flag
perdeu  in  1  game loss flag
botoes  out  4  registered button drive to the game, one-hot or 0
jogar  out  1  registered start pulse to the game
ativo  out  1  high in every state except INICIAL and FIM
db_estado  out  4  current state code
db_contagem  out  5  number of valid captured entries, 0..16
db_erro_captura  out  1  sticky: invalid pattern or overflow seen since start

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to INICIAL.
  - botoes=0, jogar=0, ativo=0, db_contagem=0, db_erro_captura=0.
  - Memory contents are don't-care.
- All outputs are registered and update only on the rising clock edge.
- State codes: INICIAL=0, PULSO_JOGAR=1, ESPERA_LEDS=2, CAPTURA=3, SILENCIO_ST=4, PRESSIONA=5, SOLTA=6, PROXIMA=7, FIM=15.
- INICIAL: on iniciar=1, go to PULSO_JOGAR. Clear db_contagem and db_erro_captura.
- PULSO_JOGAR:
  - jogar=1 for exactly JOGAR_CICLOS cycles, then jogar=0 and go to ESPERA_LEDS.
- ESPERA_LEDS: waits for leds to become nonzero.
  - leds one-hot and contagem<PROFUNDIDADE: write leds to mem[contagem], increment contagem, go to CAPTURA.
  - leds nonzero but not one-hot: no write, set db_erro_captura, go to CAPTURA.
  - leds one-hot with contagem=PROFUNDIDADE: no write, set db_erro_captura, go to CAPTURA.
  - While in ESPERA_LEDS with contagem>0, count consecutive leds=0 cycles. After SILENCIO of them, go to SILENCIO_ST.
- CAPTURA: wait for leds=0, then return to ESPERA_LEDS with the silence counter restarted at 0. A pattern held on leds is recorded only once.
- SILENCIO_ST: one cycle. Read pointer = 0, go to PRESSIONA.
- PRESSIONA:
  - botoes=mem[ptr] from the edge entering the state, held exactly HOLD cycles.
  - Then go to SOLTA.
- SOLTA: botoes=0 for exactly GAP cycles, then go to PROXIMA.
- PROXIMA:
  - ptr=contagem-1: clear contagem to 0, go to ESPERA_LEDS. The next round is recorded fresh; the game replays the full sequence each round.
  - Otherwise: increment ptr, go to PRESSIONA.
- Leds activity during PRESSIONA/SOLTA/PROXIMA is ignored (game echo).
- ganhou or perdeu:
  - Sampled high in any state other than INICIAL/FIM, it forces FIM on the next edge, overriding every other transition.
  - botoes=0 and jogar=0 on that edge.
- FIM: holds all outputs. db_contagem and db_erro_captura keep their values. iniciar=1 restarts at PULSO_JOGAR, with the same clears as INICIAL.
- iniciar is ignored in all states other than INICIAL and FIM.
- contagem is 5 bits and saturates at 16; it never wraps.
- ptr is 4 bits.
- SILENCIO counter saturates, so there is no overflow with a long idle leds.

Test Plan:
- Reset mid-replay: drive reset=0 during PRESSIONA with botoes=0100 -> botoes=0000, db_estado=0, ativo=0 within the same cycle (asynchronous); stays there until iniciar.
- Start: iniciar=1 for 1 cycle in INICIAL -> jogar=1 for exactly 5 cycles, then db_estado=2, ativo=1.
- One-round replay: leds shows 0001 for 10 cycles, then 0 for 20 cycles -> db_contagem=1; botoes=0001 for exactly 5 cycles, then 0 for 5; db_contagem=0, db_estado=2.
- Four-entry replay: leds shows 0001, 0010, 0100, 1000, each 10 cycles on and 5 off, then 20 idle -> botoes replays 0001, 0010, 0100, 1000 in order, each 5 on / 5 off (40 cycles total).
- Invalid and overflow capture: leds=0011 once -> db_erro_captura=1, db_contagem unchanged. Then 17 one-hot pulses -> db_contagem=16, 17th not stored, replay has 16 presses.
- End conditions: perdeu=1 during SOLTA -> db_estado=15 next edge, botoes=0; iniciar=1 -> jogar pulse restarts. ganhou=1 simultaneous with the PROXIMA transition -> FIM wins.

Source files
------------

// File: rtl/jogador_automatico.sv
// Autoplayer for the memory game: records the LED sequence shown each round and
// replays it on botoes with fixed press/release timing until the game ends.
module jogador_automatico #(
    parameter int unsigned HOLD         = 5,
    parameter int unsigned GAP          = 5,
    parameter int unsigned JOGAR_CICLOS = 5,
    parameter int unsigned SILENCIO     = 20,
    parameter int unsigned PROFUNDIDADE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic [3:0] botoes,
    output logic       jogar,
    output logic       ativo,
    output logic [3:0] db_estado,
    output logic [4:0] db_contagem,
    output logic       db_erro_captura
);

    localparam int unsigned CW = $clog2(PROFUNDIDADE + 1);
    localparam int unsigned PW = $clog2(PROFUNDIDADE);
    localparam int unsigned SW = $clog2(SILENCIO + 1);
    // PROXIMA contributes one zero cycle, so SOLTA dwells one less to keep GAP zeros
    localparam int unsigned SOLTA_CICLOS = (GAP > 1) ? GAP - 1 : 1;

    typedef enum logic [3:0] {
        Inicial    = 4'd0,
        PulsoJogar = 4'd1,
        EsperaLeds = 4'd2,
        Captura    = 4'd3,
        SilencioSt = 4'd4,
        Pressiona  = 4'd5,
        Solta      = 4'd6,
        Proxima    = 4'd7,
        Fim        = 4'd15
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [CW-1:0]   contagem_q, contagem_d;
    logic            erro_q, erro_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      timer_q, timer_d;
    logic [SW-1:0]   sil_q, sil_d;
    logic            mem_we;
    logic            leds_onehot;
    logic [3:0]      botoes_q, botoes_d;
    logic            jogar_q, jogar_d;
    logic            ativo_q, ativo_d;
    logic [3:0]      mem [PROFUNDIDADE];

    assign leds_onehot = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);

    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        erro_d     = erro_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q + 8'd1;
        sil_d      = sil_q;
        mem_we     = 1'b0;

        unique case (estado_q)
            Inicial, Fim: begin
                if (iniciar) begin
                    estado_d   = PulsoJogar;
                    contagem_d = '0;
                    erro_d     = 1'b0;
                    timer_d    = 8'd0;
                end
            end
            PulsoJogar: begin
                if (timer_q == 8'(JOGAR_CICLOS - 1)) begin
                    estado_d = EsperaLeds;
                    sil_d    = '0;
                end
            end
            EsperaLeds: begin
                if (leds != 4'd0) begin
                    estado_d = Captura;
                    sil_d    = '0;
                    if (!leds_onehot || contagem_q == CW'(PROFUNDIDADE)) begin
                        erro_d = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        contagem_d = contagem_q + CW'(1);
                    end
                end else if (contagem_q != '0) begin
                    if (sil_q != SW'(SILENCIO)) sil_d = sil_q + SW'(1);
                    if (sil_q >= SW'(SILENCIO - 1)) estado_d = SilencioSt;
                end
            end
            Captura: begin
                if (leds == 4'd0) begin
                    estado_d = EsperaLeds;
                    sil_d    = '0;
                end
            end
            SilencioSt: begin
                ptr_d    = '0;
                timer_d  = 8'd0;
                estado_d = Pressiona;
            end
            Pressiona: begin
                if (timer_q == 8'(HOLD - 1)) begin
                    estado_d = Solta;
                    timer_d  = 8'd0;
                end
            end
            Solta: begin
                if (timer_q == 8'(SOLTA_CICLOS - 1)) estado_d = Proxima;
            end
            Proxima: begin
                if (CW'(ptr_q) == contagem_q - CW'(1)) begin
                    contagem_d = '0;
                    sil_d      = '0;
                    estado_d   = EsperaLeds;
                end else begin
                    ptr_d    = ptr_q + PW'(1);
                    timer_d  = 8'd0;
                    estado_d = Pressiona;
                end
            end
            default: estado_d = Inicial;
        endcase

        // End of game preempts everything, including pending captures and clears
        if (estado_q != Inicial && estado_q != Fim && (ganhou || perdeu)) begin
            estado_d   = Fim;
            contagem_d = contagem_q;
            erro_d     = erro_q;
            mem_we     = 1'b0;
        end

        botoes_d = (estado_d == Pressiona) ? mem[ptr_d] : 4'd0;
        jogar_d  = (estado_d == PulsoJogar);
        ativo_d  = (estado_d != Inicial) && (estado_d != Fim);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= Inicial;
            contagem_q <= '0;
            erro_q     <= 1'b0;
            ptr_q      <= '0;
            timer_q    <= 8'd0;
            sil_q      <= '0;
            botoes_q   <= 4'd0;
            jogar_q    <= 1'b0;
            ativo_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
            erro_q     <= erro_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            sil_q      <= sil_d;
            botoes_q   <= botoes_d;
            jogar_q    <= jogar_d;
            ativo_q    <= ativo_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[contagem_q[PW-1:0]] <= leds;
    end

    assign botoes          = botoes_q;
    assign jogar           = jogar_q;
    assign ativo           = ativo_q;
    assign db_estado       = estado_q;
    assign db_contagem     = 5'(contagem_q);
    assign db_erro_captura = erro_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: captured LED patterns go into a scoreboard
// queue and are popped as the autoplayer replays them on botoes.
module tb_jogador_automatico;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] botoes;
    logic       jogar;
    logic       ativo;
    logic [3:0] db_estado;
    logic [4:0] db_contagem;
    logic       db_erro_captura;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    jogador_automatico dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .leds           (leds),
        .ganhou         (ganhou),
        .perdeu         (perdeu),
        .botoes         (botoes),
        .jogar          (jogar),
        .ativo          (ativo),
        .db_estado      (db_estado),
        .db_contagem    (db_contagem),
        .db_erro_captura(db_erro_captura)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic start_game();
        int len;
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        len = 0;
        while (jogar && len < 20) begin
            len++;
            tick(1);
        end
        chk("jogar_len", len, 5);
        chk("estado_after_jogar", db_estado, 2);
        chk("ativo_after_jogar", ativo, 1);
    endtask

    // Show one pattern; push to the scoreboard only if it should be stored
    task automatic show(input logic [3:0] p, input int on, input int off, input bit stored);
        if (stored) exp_q.push_back(p);
        leds = p;
        tick(on);
        leds = 4'd0;
        tick(off);
    endtask

    task automatic wait_press(output logic [3:0] e);
        int w;
        w = 0;
        while (botoes == 4'd0 && w < 200) begin
            w++;
            tick(1);
        end
        chk("press_seen", 32'(botoes != 4'd0), 1);
        chk("queue_nonempty", 32'(exp_q.size() != 0), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'd0;
        chk("press_val", botoes, e);
    endtask

    task automatic replay(input int n);
        logic [3:0] e;
        int len;
        int gap;
        for (int k = 0; k < n; k++) begin
            wait_press(e);
            len = 0;
            while (botoes == e && e != 4'd0 && len < 20) begin
                len++;
                tick(1);
            end
            chk("press_len", len, 5);
            gap = 0;
            while (botoes == 4'd0 && (db_estado == 4'd6 || db_estado == 4'd7) && gap < 20) begin
                gap++;
                tick(1);
            end
            chk("gap_len", gap, 5);
        end
        chk("estado_after_replay", db_estado, 2);
        chk("contagem_after_replay", db_contagem, 0);
    endtask

    task automatic wait_state(input logic [3:0] s);
        int w;
        w = 0;
        while (db_estado != s && w < 200) begin
            w++;
            tick(1);
        end
        chk("wait_state", db_estado, s);
    endtask

    initial begin
        logic [3:0] e;
        reset   = 1'b1;
        iniciar = 1'b0;
        leds    = 4'd0;
        ganhou  = 1'b0;
        perdeu  = 1'b0;
        #2 reset = 1'b0;
        tick(2);
        chk("rst_botoes", botoes, 0);
        chk("rst_jogar", jogar, 0);
        chk("rst_ativo", ativo, 0);
        chk("rst_estado", db_estado, 0);
        chk("rst_contagem", db_contagem, 0);
        chk("rst_erro", db_erro_captura, 0);
        reset = 1'b1;
        tick(3);
        chk("idle_estado", db_estado, 0);

        start_game();

        // One-entry round
        show(4'b0001, 10, 0, 1'b1);
        chk("one_contagem", db_contagem, 1);
        replay(1);

        // Four-entry round
        show(4'b0001, 10, 5, 1'b1);
        show(4'b0010, 10, 5, 1'b1);
        show(4'b0100, 10, 5, 1'b1);
        show(4'b1000, 10, 5, 1'b1);
        chk("four_contagem", db_contagem, 4);
        replay(4);

        // Invalid pattern then overflow: 17 one-hot pulses, only 16 stored
        show(4'b0001, 10, 3, 1'b1);
        show(4'b0011, 3, 3, 1'b0);
        chk("invalid_erro", db_erro_captura, 1);
        chk("invalid_contagem", db_contagem, 1);
        for (int i = 1; i < 17; i++) begin
            e = 4'b0001 << (i % 4);
            show(e, 10, 3, i < 16);
        end
        chk("overflow_contagem", db_contagem, 16);
        chk("overflow_erro", db_erro_captura, 1);
        replay(16);
        chk("erro_sticky", db_erro_captura, 1);

        // Loss during SOLTA
        show(4'b0100, 10, 5, 1'b1);
        wait_press(e);
        wait_state(4'd6);
        perdeu = 1'b1;
        tick(1);
        perdeu = 1'b0;
        chk("perdeu_estado", db_estado, 15);
        chk("perdeu_botoes", botoes, 0);
        chk("perdeu_ativo", ativo, 0);
        chk("fim_contagem_kept", db_contagem, 1);
        tick(3);
        chk("fim_hold", db_estado, 15);
        start_game();
        chk("restart_contagem", db_contagem, 0);
        chk("restart_erro", db_erro_captura, 0);

        // Win coinciding with the PROXIMA transition
        show(4'b0010, 10, 5, 1'b1);
        wait_press(e);
        wait_state(4'd7);
        ganhou = 1'b1;
        tick(1);
        ganhou = 1'b0;
        chk("ganhou_estado", db_estado, 15);
        chk("ganhou_botoes", botoes, 0);
        chk("ganhou_contagem_kept", db_contagem, 1);

        // Asynchronous reset in the middle of a press
        start_game();
        show(4'b0100, 10, 5, 1'b1);
        wait_press(e);
        #2 reset = 1'b0;
        #1;
        chk("async_botoes", botoes, 0);
        chk("async_estado", db_estado, 0);
        chk("async_ativo", ativo, 0);
        tick(1);
        reset = 1'b1;
        tick(4);
        chk("post_reset_estado", db_estado, 0);
        chk("post_reset_jogar", jogar, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
